// File: rtl/sipo_deser_pkg.sv
// sipo_deser shared types and sizing helpers.
// Imported by the interface, the holding register and the top.
package sipo_pkg;

   localparam int N_DEF = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   // Counter width for an N-bit word; never narrower than one bit.
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int CW_DEF = cw(N_DEF);

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input and parallel valid/ready output bundle of sipo_deser.
// master = producer/consumer side, slave = deserializer side.
interface sipo_if
   import sipo_pkg::*;
#(
   parameter int N = N_DEF
);

   localparam int CW = cw(N);

   logic          en;
   logic          d;
   logic          ready;
   logic [N-1:0]  q;
   logic          valid;
   logic          ovf;
   logic [CW-1:0] bitcnt;

   modport master (
      output en,
      output d,
      output ready,
      input  q,
      input  valid,
      input  ovf,
      input  bitcnt
   );

   modport slave (
      input  en,
      input  d,
      input  ready,
      output q,
      output valid,
      output ovf,
      output bitcnt
   );

endinterface

// File: rtl/sipo_deser_flopenr.sv
// N-bit enabled flop with synchronous active-high reset.
// Holds the delivered word of sipo_deser.
module sipo_deser_flopenr #(
   parameter int N = 8
) (
   input  logic         i_clk,
   input  logic         i_r,
   input  logic         i_en,
   input  logic [N-1:0] i_d,
   output logic [N-1:0] o_q
);

   logic [N-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_r)
         r_q <= '0;
      else if (i_en)
         r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer with valid/ready output
// and sticky overrun flag.
module sipo_deser
   import sipo_pkg::*;
#(
   parameter int N         = N_DEF,
   parameter bit LSB_FIRST = 1'b0
) (
   input logic  clk,
   input logic  r,
   sipo_if.slave bus
);

   localparam int CW = cw(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic [N-1:0]  r_sr;
   logic [CW-1:0] r_cnt;
   state_t        r_state;
   logic          r_ovf;

   state_t        w_next;
   logic          w_done;
   logic          w_load;
   logic          w_ovf_set;
   logic [N-1:0]  w_word;

   assign w_done = bus.en && (r_cnt == LAST);

   // Word as it will look after this edge's shift, including d.
   always_comb begin
      w_word = LSB_FIRST ? {bus.d, r_sr[N-1:1]}
                         : {r_sr[N-2:0], bus.d};
   end

   always_ff @(posedge clk) begin
      if (r) begin
         r_sr  <= '0;
         r_cnt <= '0;
      end else if (bus.en) begin
         r_sr  <= w_word;
         r_cnt <= w_done ? '0 : r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (r)
         r_state <= EMPTY;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_load    = 1'b0;
      w_ovf_set = 1'b0;
      unique case (r_state)
         EMPTY: begin
            if (w_done) begin
               w_load = 1'b1;
               w_next = FULL;
            end
         end
         FULL: begin
            if (w_done && bus.ready)
               w_load = 1'b1;
            else if (w_done)
               w_ovf_set = 1'b1;
            else if (bus.ready)
               w_next = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (r)
         r_ovf <= 1'b0;
      else if (w_ovf_set)
         r_ovf <= 1'b1;
   end

   sipo_deser_flopenr #(
      .N (N)
   ) u_hold (
      .i_clk (clk),
      .i_r   (r),
      .i_en  (w_load),
      .i_d   (w_word),
      .o_q   (bus.q)
   );

   assign bus.valid  = (r_state == FULL);
   assign bus.ovf    = r_ovf;
   assign bus.bitcnt = r_cnt;

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances on one stream,
// checked every cycle against a bit-queue model plus literal spot checks.
module tb_sipo_deser;
   import sipo_pkg::*;

   localparam int N = 8;

   logic clk = 1'b0;
   logic r, en, d, ready;

   always #5 clk = ~clk;

   sipo_if #(.N(N)) b0 ();
   sipo_if #(.N(N)) b1 ();

   assign b0.en = en;
   assign b0.d = d;
   assign b0.ready = ready;
   assign b1.en = en;
   assign b1.d = d;
   assign b1.ready = ready;

   sipo_deser #(.N(N), .LSB_FIRST(1'b0)) u0 (
      .clk (clk),
      .r   (r),
      .bus (b0.slave)
   );

   sipo_deser #(.N(N), .LSB_FIRST(1'b1)) u1 (
      .clk (clk),
      .r   (r),
      .bus (b1.slave)
   );

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   logic [N-1:0] mq0, mq1;
   bit mvalid, movf;
   bit mb[$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: collect bits in a queue, build the word when N are in.
   always @(posedge clk) begin : model
      logic [N-1:0] w0, w1;
      bit done;
      done = 1'b0;
      w0 = '0;
      w1 = '0;
      if (r) begin
         mb.delete();
         mq0 = '0;
         mq1 = '0;
         mvalid = 1'b0;
         movf = 1'b0;
         started = 1'b1;
      end else begin
         if (en) begin
            mb.push_back(d);
            if (mb.size() == N) begin
               for (int i = 0; i < N; i++) begin
                  w0[N-1-i] = mb[i];
                  w1[i] = mb[i];
               end
               mb.delete();
               done = 1'b1;
            end
         end
         if (!mvalid) begin
            if (done) begin
               mq0 = w0;
               mq1 = w1;
               mvalid = 1'b1;
            end
         end else if (done) begin
            if (ready) begin
               mq0 = w0;
               mq1 = w1;
            end else begin
               movf = 1'b1;
            end
         end else if (ready) begin
            mvalid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("q0", 32'(b0.q), 32'(mq0));
         chk("q1", 32'(b1.q), 32'(mq1));
         chk("valid0", 32'(b0.valid), 32'(mvalid));
         chk("valid1", 32'(b1.valid), 32'(mvalid));
         chk("ovf0", 32'(b0.ovf), 32'(movf));
         chk("ovf1", 32'(b1.ovf), 32'(movf));
         chk("bitcnt0", 32'(b0.bitcnt), 32'(mb.size()));
         chk("bitcnt1", 32'(b1.bitcnt), 32'(mb.size()));
      end
   end

   task automatic cyc(bit rr, bit ee, bit dd, bit rd);
      r = rr;
      en = ee;
      d = dd;
      ready = rd;
      @(negedge clk);
   endtask

   task automatic send(logic [7:0] w, bit rd_last);
      for (int i = 7; i >= 0; i--)
         cyc(1'b0, 1'b1, w[i], (i == 0) ? rd_last : 1'b0);
   endtask

   initial begin
      logic [7:0] wb2;
      wb2 = 8'hB2;
      r = 1'b1;
      en = 1'b0;
      d = 1'b0;
      ready = 1'b0;
      @(negedge clk);

      // Reset then stream
      cyc(1, 0, 0, 0);
      chk("rst_valid", 32'(b0.valid), 0);
      chk("rst_ovf", 32'(b0.ovf), 0);
      chk("rst_bitcnt", 32'(b0.bitcnt), 0);
      chk("rst_q", 32'(b0.q), 0);
      for (int i = 7; i >= 1; i--)
         cyc(0, 1, wb2[i], 0);
      chk("pre_valid", 32'(b0.valid), 0);
      cyc(0, 1, wb2[0], 0);
      chk("msb_q", 32'(b0.q), 32'h00B2);
      chk("lsb_q", 32'(b1.q), 32'h004D);
      chk("msb_valid", 32'(b0.valid), 1);
      chk("msb_ovf", 32'(b0.ovf), 0);

      // Gapped enable
      cyc(1, 0, 0, 0);
      for (int i = 7; i >= 5; i--)
         cyc(0, 1, wb2[i], 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 1'($urandom), 0);
         chk("gap_bitcnt", 32'(b0.bitcnt), 3);
      end
      for (int i = 4; i >= 0; i--)
         cyc(0, 1, wb2[i], 0);
      chk("gap_q", 32'(b0.q), 32'h00B2);
      chk("gap_valid", 32'(b0.valid), 1);

      // Back-to-back words, ready on completing edge
      cyc(1, 0, 0, 0);
      send(8'hB2, 0);
      send(8'h5A, 1);
      chk("b2b_q", 32'(b0.q), 32'h005A);
      chk("b2b_valid", 32'(b0.valid), 1);
      chk("b2b_ovf", 32'(b0.ovf), 0);

      // Overrun, sticky through later transfers
      cyc(1, 0, 0, 0);
      send(8'hB2, 0);
      send(8'hFF, 0);
      chk("ovr_q", 32'(b0.q), 32'h00B2);
      chk("ovr_ovf", 32'(b0.ovf), 1);
      cyc(0, 0, 0, 1);
      chk("ovr_xfer_valid", 32'(b0.valid), 0);
      chk("ovr_xfer_ovf", 32'(b0.ovf), 1);
      send(8'h3C, 1);
      chk("ovr_sticky", 32'(b0.ovf), 1);
      cyc(1, 0, 0, 0);
      chk("ovr_clear", 32'(b0.ovf), 0);

      // Reset mid-word
      for (int i = 0; i < 5; i++)
         cyc(0, 1, 1'($urandom), 0);
      cyc(1, 1, 1, 1);
      chk("mid_valid", 32'(b0.valid), 0);
      chk("mid_ovf", 32'(b0.ovf), 0);
      chk("mid_bitcnt", 32'(b0.bitcnt), 0);
      send(8'h3C, 0);
      chk("mid_q", 32'(b0.q), 32'h003C);

      // Random traffic
      repeat (3000)
         cyc($urandom_range(0, 99) == 0, ($urandom % 4) != 0,
             1'($urandom), ($urandom % 3) == 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Serial-in, parallel-out deserializer that sits directly downstream of the enabled resettable bit flop (flopenr).
- It consumes that flop's registered serial bit stream, qualified by the same enable.
- Assembles N-bit words and presents each word on a valid/ready output handshake.
- Flags overrun when a completed word cannot be delivered.

Parameters:
- N, 8, word width in bits; legal range 2..32.
- LSB_FIRST, 0, 0 = first received bit lands in q[N-1] (MSB-first); 1 = first received bit lands in q[0].

Ports:
- clk  input  1  rising-edge clock
- r  input  1  synchronous active-high reset
- en  input  1  serial bit qualifier; d is sampled only when en=1
- d  input  1  serial data bit (driven by upstream flopenr y)
- ready  input  1  consumer accepts q this edge when valid=1
- q  output  N  assembled word; stable while valid=1
- valid  output  1  q holds an undelivered word
- ovf  output  1  sticky overrun flag
- bitcnt  output  $clog2(N)  bits collected in the current word (debug)

Behaviour:
- Reset (r=1 at rising edge, dominates every other input):
  - shift register sr=0, bitcnt=0, q=0, valid=0, ovf=0.
  - Reset mid-word discards the partial word.
- Shift rules (edge with en=1):
  - LSB_FIRST=0: sr <= {sr[N-2:0], d}.
  - LSB_FIRST=1: sr <= {d, sr[N-1:1]}.
  - bitcnt <= bitcnt+1.
  - Edge with en=0: sr and bitcnt hold; d is ignored.
- Word complete: an edge with en=1 and bitcnt==N-1.
  - The assembled word includes the current d.
  - bitcnt wraps to 0 on the same edge; the next en bit starts a new word with no gap cycle.
- Output register is a two-state machine, EMPTY (valid=0) and FULL (valid=1).
- EMPTY:
  - Word complete -> q <= word, go FULL.
  - valid rises the cycle after the edge sampling bit N (latency of 1 clock from the last bit).
- FULL, ready=1 with no word complete -> transfer; go EMPTY; q holds its last value.
- FULL, ready=1 with word complete on the same edge -> q <= new word, stay FULL, ovf unchanged.
- FULL, ready=0 with word complete -> new word dropped, q unchanged, stay FULL, ovf <= 1.
- FULL, ready=0 with no word complete -> hold.
- ready is ignored while EMPTY.
- ovf stays set until reset.
- q, valid and ovf come straight from registers (no combinational path from inputs).

Decomposition:
- Package sipo_pkg:
  - state enum {EMPTY, FULL};
  - localparam CW = $clog2(N) as a function of N;
  - default N.
- The output holding register is a natural sub-module: flopenr widened to N bits.
  - enable = load (word complete and (EMPTY or ready));
  - reset = r.
- Shift register, counter and FSM stay in sipo_deser.

Test Plan:
- Reset then stream: r=1 for one edge, then en=1 continuously with d = 1,0,1,1,0,0,1,0 (N=8, MSB-first), ready=0 -> valid rises one cycle after the 8th edge, q=8'hB2, ovf=0.
- Same bit stream with LSB_FIRST=1 -> q=8'h4D.
- Gapped enable: same bits, but en low for 3 cycles between bits 3 and 4 -> q=8'hB2, and bitcnt holds at 3 during the gap.
- Back-to-back words: 16 consecutive bits 8'hB2 then 8'h5A, ready pulsed 1 on the edge completing the second word -> q=8'h5A, valid stays 1, ovf=0.
- Overrun: word 8'hB2 delivered, ready held 0, next 8 bits form 8'hFF -> q stays 8'hB2, ovf=1 and stays 1 through later transfers until r.
- Reset mid-word: after 5 bits of a word, assert r for one edge, then send 8 bits of 8'h3C -> q=8'h3C; valid, ovf and bitcnt were 0 immediately after the reset edge.
